// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Two-port arbiter in front of a single-ported, combinational-read word
//   memory. Port A is the pipeline MEM stage, port B the debug/loader port.
//   Each transaction is latched in IDLE and then runs to completion through
//   ACCESS (and MERGE for partial-byte writes, done as read-modify-write)
//   before a one-cycle ack in DONE.
//
//   Configuration macro: DMEM_ARB_FIXED_PRIO_EN
//     defined   -> port A always wins a tie, no last-grant register
//     undefined -> round-robin on ties (port not granted last wins)
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   a_req/b_req                   transaction request (held until ack)
//   a_we/b_we                     1 = write, 0 = read
//   a_addr/b_addr   [6:0]         word address
//   a_wdata/b_wdata [31:0]        lane-aligned write data
//   a_be/b_be       [3:0]         byte enables, bit i = byte lane i
//   a_ack/b_ack                   one-cycle completion pulse
//   rd_data         [31:0]        registered read data, valid with ack
//   a_stall                       pipeline freeze for port A
//   busy                          arbiter not idle
//   mem_addr/mem_we/mem_wdata     memory write/address side
//   mem_rdata       [31:0]        combinational memory read data
// -----------------------------------------------------------------------------
module data_mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [6:0]  a_addr,
   input  logic [31:0] a_wdata,
   input  logic [3:0]  a_be,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [6:0]  b_addr,
   input  logic [31:0] b_wdata,
   input  logic [3:0]  b_be,
   output logic        a_ack,
   output logic        b_ack,
   output logic [31:0] rd_data,
   output logic        a_stall,
   output logic        busy,
   output logic [6:0]  mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_MERGE  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t      state_q, state_d;

   // Latched transaction (owner: 0 = port A, 1 = port B)
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic [6:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;

   logic [31:0] rd_data_q, rd_data_d;
   logic [31:0] merge_q, merge_d;     // old word captured for read-modify-write

   logic        grant_b;
   logic [31:0] merged_wdata;

   // -------------------------------------------------------------------------
   // Arbitration: decides which port wins when sampled in IDLE
   // -------------------------------------------------------------------------
`ifdef DMEM_ARB_FIXED_PRIO_EN
   assign grant_b = b_req & ~a_req;
`else
   logic last_grant_q, last_grant_d;  // 1 = port B was granted last

   // On a tie, B wins only if A was the last one served.
   assign grant_b = b_req & (~a_req | ~last_grant_q);
`endif

   // Byte-lane merge of new write data over the captured old word
   always_comb begin
      merged_wdata = merge_q;
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) merged_wdata[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its _d input, independent of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         rd_data_q    <= '0;
         merge_q      <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;         // B counts as last, so A wins first tie
`endif
      end else begin
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         rd_data_q    <= rd_data_d;
         merge_q      <= merge_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and datapath-next logic
   // -------------------------------------------------------------------------
   // NOTE: every signal written here gets a hold/default value first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      rd_data_d    = rd_data_q;
      merge_d      = merge_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (a_req | b_req) begin
               owner_d = grant_b;
               we_d    = grant_b ? b_we    : a_we;
               addr_d  = grant_b ? b_addr  : a_addr;
               wdata_d = grant_b ? b_wdata : a_wdata;
               be_d    = grant_b ? b_be    : a_be;
`ifndef DMEM_ARB_FIXED_PRIO_EN
               last_grant_d = grant_b;
`endif
               state_d = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if (!we_q) begin
               rd_data_d = mem_rdata;
               state_d   = ST_DONE;
            end else if (be_q == 4'b1111 || be_q == 4'b0000) begin
               // Full write goes straight to memory; empty mask writes nothing.
               state_d = ST_DONE;
            end else begin
               merge_d = mem_rdata;
               state_d = ST_MERGE;
            end
         end

         ST_MERGE: state_d = ST_DONE;

         ST_DONE:  state_d = ST_IDLE;

         default:  state_d = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs: decoded from state and latched fields only
   // -------------------------------------------------------------------------
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = wdata_q;
      a_ack     = 1'b0;
      b_ack     = 1'b0;

      unique case (state_q)
         ST_ACCESS: mem_we = we_q & (be_q == 4'b1111);
         ST_MERGE: begin
            mem_we    = 1'b1;
            mem_wdata = merged_wdata;
         end
         ST_DONE: begin
            a_ack = ~owner_q;
            b_ack = owner_q;
         end
         default: ;
      endcase
   end

   assign mem_addr = addr_q;
   assign rd_data  = rd_data_q;
   assign busy     = (state_q != ST_IDLE);
   assign a_stall  = a_req & ~a_ack;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Scoreboard bench for data_mem_arbiter. Each issued transaction pushes its
//   expected owner and rd_data; a monitor pops and compares on every ack.
//   A behavioural word memory sits on the mem_* side. Honors
//   DMEM_ARB_FIXED_PRIO_EN for the tie-break expectations.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [6:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic [3:0]  a_be, b_be;
   logic        a_ack, b_ack, a_stall, busy, mem_we;
   logic [31:0] rd_data, mem_wdata, mem_rdata;
   logic [6:0]  mem_addr;

   // Preload side-door into the memory model
   logic        pl_en;
   logic [6:0]  pl_addr;
   logic [31:0] pl_data;

   logic [31:0] mem [128];

   typedef struct packed {
      logic        port_b;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   data_mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_be      (a_be),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_be      (b_be),
      .a_ack     (a_ack),
      .b_ack     (b_ack),
      .rd_data   (rd_data),
      .a_stall   (a_stall),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Word memory: combinational read, synchronous write
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Scoreboard monitor: every ack must match the oldest expected entry
   always @(negedge clk) begin
      if (!rst && (a_ack || b_ack)) begin
         check("dual_ack", {31'd0, a_ack & b_ack}, 32'd0);
         if (sb_q.size() == 0) begin
            check("ack_with_empty_sb", 32'(sb_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_owner_b", {31'd0, b_ack}, {31'd0, e.port_b});
            check("sb_rd_data", rd_data, e.rdata);
         end
      end
   end

   task automatic preload(input logic [6:0] addr, input logic [31:0] data);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = addr;
      pl_data = data;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   // Issues one transaction on one port, waits (bounded) for its ack and
   // checks latency, mem_we cycle count and port-A stall behaviour.
   task automatic issue(input string tag, input bit port_b, input bit we,
                        input logic [6:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd,
                        input int exp_lat, input int exp_we_cycles);
      int   n;
      int   we_seen;
      logic acked;
      exp_t e;
      e.port_b = port_b;
      e.rdata  = exp_rd;
      sb_q.push_back(e);
      @(negedge clk);
      if (port_b) begin
         b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
      end else begin
         a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_be = be;
      end
      n = 0;
      we_seen = 0;
      acked = 1'b0;
      while (!acked && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (mem_we) we_seen++;
         if (n == 1 && !port_b) check({tag, "_stall_wait"}, {31'd0, a_stall}, 32'd1);
         acked = port_b ? b_ack : a_ack;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_we_cycles"}, we_seen, exp_we_cycles);
      check({tag, "_stall_at_ack"}, {31'd0, a_stall}, 32'd0);
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   initial begin
      int   acks;
      exp_t e;

      rst = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
      pl_en = 0; pl_addr = '0; pl_data = '0;

      preload(7'h05, 32'hDEADBEEF);
      preload(7'h03, 32'hAABBCCDD);
      preload(7'h10, 32'h0BADF00D);
      preload(7'h20, 32'h11223344);
      preload(7'h30, 32'hCAFEBABE);

      // Reset values
      check("rst_a_ack",   {31'd0, a_ack},  32'd0);
      check("rst_b_ack",   {31'd0, b_ack},  32'd0);
      check("rst_rd_data", rd_data,          32'd0);
      check("rst_busy",    {31'd0, busy},   32'd0);
      check("rst_mem_we",  {31'd0, mem_we}, 32'd0);

      @(negedge clk);
      rst = 1'b0;

      // Read from A
      issue("a_rd5", 1'b0, 1'b0, 7'h05, 32'h0, 4'b1111, 32'hDEADBEEF, 2, 0);

      // Full write from A; rd_data must keep the last read value
      issue("a_wr10", 1'b0, 1'b1, 7'h10, 32'h12345678, 4'b1111, 32'hDEADBEEF, 2, 1);
      check("mem10", mem[7'h10], 32'h12345678);

      // Partial write from B (read-modify-write)
      issue("b_wr3", 1'b1, 1'b1, 7'h03, 32'h0000EE00, 4'b0010, 32'hDEADBEEF, 3, 1);
      check("mem3", mem[7'h03], 32'hAABBEEDD);

      // Empty byte mask: acked, memory untouched
      issue("a_wr30_be0", 1'b0, 1'b1, 7'h30, 32'hFFFFFFFF, 4'b0000, 32'hDEADBEEF, 2, 0);
      check("mem30", mem[7'h30], 32'hCAFEBABE);

      // Read back from B
      issue("b_rd10", 1'b1, 1'b0, 7'h10, 32'h0, 4'b0000, 32'h12345678, 2, 0);

      // Reset in the MERGE cycle of a partial write
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 7'h20; a_wdata = 32'hFFFFFFFF; a_be = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("merge_mem_we", {31'd0, mem_we}, 32'd1);
      check("merge_busy",   {31'd0, busy},   32'd1);
      rst = 1'b1;
      a_req = 1'b0;
      #1;
      check("rst_mid_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mid_busy",   {31'd0, busy},   32'd0);
      check("rst_mid_a_ack",  {31'd0, a_ack},  32'd0);
      check("rst_mid_rd",     rd_data,          32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mem20_kept", mem[7'h20], 32'h11223344);

      // Both ports held together for four transactions
`ifdef DMEM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) begin
         e.port_b = 1'b0; e.rdata = 32'hDEADBEEF; sb_q.push_back(e);
      end
`else
      for (int i = 0; i < 2; i++) begin
         e.port_b = 1'b0; e.rdata = 32'hDEADBEEF; sb_q.push_back(e);
         e.port_b = 1'b1; e.rdata = 32'hAABBEEDD; sb_q.push_back(e);
      end
`endif
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 7'h05; a_be = 4'b1111;
      b_req = 1'b1; b_we = 1'b0; b_addr = 7'h03; b_be = 4'b1111;
      acks = 0;
      for (int c = 0; c < 60 && acks < 4; c++) begin
         @(negedge clk);
         if (a_ack || b_ack) acks++;
      end
      a_req = 1'b0;
      b_req = 1'b0;
      check("tie_ack_count", acks, 4);
      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("idle_at_end", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: a_req/b_req  in  1 each  request, port A = pipeline MEM stage, port B = debug/loader.
REQ-004 SHALL have ports: a_we/b_we  in  1 each  1 = write, 0 = read.
REQ-005 SHALL have ports: a_addr/b_addr  in  7 each  word address [8:2].
REQ-006 SHALL have ports: a_wdata/b_wdata  in  32 each  write data, lane-aligned.
REQ-007 SHALL have ports: a_be/b_be  in  4 each  byte enables, bit i = byte [8i+7:8i].
REQ-008 SHALL have ports: a_ack/b_ack  out  1 each  one-cycle completion pulse.
REQ-009 SHALL have ports: rd_data  out  32  registered read data, valid while a_ack or b_ack is high.
REQ-010 SHALL have ports: a_stall  out  1  = a_req & ~a_ack, pipeline freeze.
REQ-011 SHALL have ports: busy  out  1  high whenever state != IDLE.
REQ-012 SHALL have ports: mem_addr  out  7, mem_we  out  1, mem_wdata  out  32, mem_rdata  in  32 (combinational-read word memory).

Function
REQ-013 SHALL implement FSM IDLE, ACCESS, MERGE, DONE; requests sampled only in IDLE.
REQ-014 IDLE: on any req, latch winner's we/addr/wdata/be and owner; go to ACCESS; else stay IDLE.
REQ-015 ACCESS: mem_addr = latched addr; read -> capture mem_rdata into rd_data, go DONE.
REQ-016 ACCESS, write, be=4'b1111 -> mem_we=1, mem_wdata=latched wdata, go DONE.
REQ-017 ACCESS, write, be partial (nonzero) -> capture mem_rdata into merge register, go MERGE.
REQ-018 ACCESS, write, be=4'b0000 -> no memory write, go DONE (ack still issued).
REQ-019 MERGE: mem_we=1, mem_wdata byte i = be[i] ? wdata byte i : captured byte i; go DONE.
REQ-020 DONE: owner's ack high for exactly this cycle; go IDLE unconditionally.
REQ-021 Latency: read and full write ack on 2nd cycle after request sampled; partial write on 3rd; max throughput one transaction per 3 (4) cycles.
REQ-022 mem_we SHALL be decoded from state only, never high outside ACCESS/MERGE.
REQ-023 Requester SHALL hold req and fields until ack; arbiter completes a latched transaction even if req drops.
REQ-024 Both req in IDLE: round-robin, grant port not granted last; single req granted immediately.
REQ-025 rd_data SHALL hold last read value until next read capture; write transactions leave it unchanged.
REQ-026 Same-port back-to-back requests: the new request is sampled in the IDLE cycle after DONE.

Reset
REQ-027 On rst: state=IDLE, a_ack=b_ack=0, rd_data=0, merge register=0, last-grant=B (A wins first tie), busy=0, mem_we=0 immediately.
REQ-028 Reset mid-transaction SHALL abandon it with no memory write and no ack.

Configuration
REQ-029 Macro DMEM_ARB_FIXED_PRIO_EN defined: port A always wins ties, last-grant register absent; undefined: round-robin per REQ-024.

Verification
REQ-030 Reset, a_req read addr 7'h05 with mem[5]=32'hDEADBEEF -> a_ack on 2nd cycle, rd_data=32'hDEADBEEF, mem_we never high.
REQ-031 a_req write addr 7'h10, be=4'b1111, wdata=32'h12345678 -> one mem_we cycle, mem[0x10]=32'h12345678, a_ack next cycle.
REQ-032 mem[3]=32'hAABBCCDD, b_req write be=4'b0010, wdata=32'h0000EE00 -> mem[3]=32'hAABBEEDD, b_ack on 3rd cycle, a_stall unaffected.
REQ-033 a_req and b_req held together for 4 transactions -> grants A,B,A,B; with DMEM_ARB_FIXED_PRIO_EN -> A,A,A,A while A held.
REQ-034 rst asserted in MERGE cycle of partial write -> mem_we drops immediately, memory unchanged, no ack, busy=0.
